// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO write arbiter: FSM encoding, write-source
// encoding and the field layout of the GPIO LED/counter_set register.
package gpio_pkg;

    localparam int DW_DEFAULT = 32;

    localparam int CNTSET_LSB = 0;
    localparam int LED_LSB    = 2;
    localparam int GPIOF0_LSB = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    typedef enum logic {
        SRC_CPU = 1'b0,
        SRC_SEQ = 1'b1
    } src_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin pick: combinational grant plus a registered
// last-winner flag that hands priority to whoever was not served last.
module rr_arb2
    import gpio_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_cpu,
    input  logic req_seq,
    output logic gnt_cpu,
    output logic gnt_seq
);

    src_e last_q, last_d;

    always_comb begin
        gnt_cpu = 1'b0;
        gnt_seq = 1'b0;
        last_d  = last_q;
        if (en) begin
            if (req_cpu && (!req_seq || last_q == SRC_SEQ)) begin
                gnt_cpu = 1'b1;
            end else if (req_seq) begin
                gnt_seq = 1'b1;
            end
        end
        if (gnt_cpu) begin
            last_d = SRC_CPU;
        end else if (gnt_seq) begin
            last_d = SRC_SEQ;
        end
    end

    // Reset to "seq served last" so the CPU wins the first contest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= SRC_SEQ;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/gpio_wr_arbiter.sv
// Arbitrates CPU and pattern-sequencer writes onto the GPIO register with a
// forced idle gap; GPIO_ARB_SHADOW_EN adds shadow_q/wr_src readback ports.
module gpio_wr_arbiter
    import gpio_pkg::*;
#(
    parameter int DW  = DW_DEFAULT,
    parameter int GAP = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic [DW-1:0] cpu_data,
    input  logic          seq_req,
    input  logic [DW-1:0] seq_data,
    output logic          cpu_gnt,
    output logic          seq_gnt,
    output logic          gpio_we,
    output logic [DW-1:0] gpio_wdata,
    output logic          busy
`ifdef GPIO_ARB_SHADOW_EN
    ,
    output logic [DW-1:0] shadow_q,
    output logic          wr_src
`endif
);

    localparam logic [3:0] GAP_LOAD = 4'((GAP > 0) ? GAP - 1 : 0);

    state_e        state_q, state_d;
    logic [3:0]    gap_cnt_q, gap_cnt_d;
    logic          gpio_we_q, gpio_we_d;
    logic [DW-1:0] gpio_wdata_q, gpio_wdata_d;
    logic          arb_en;

    assign arb_en = (state_q == ST_IDLE);

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (arb_en),
        .req_cpu (cpu_req),
        .req_seq (seq_req),
        .gnt_cpu (cpu_gnt),
        .gnt_seq (seq_gnt)
    );

    // The write word is captured straight into the output register at the
    // grant edge, so it is on gpio_wdata during WR and held afterwards.
    always_comb begin
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        gpio_we_d    = 1'b0;
        gpio_wdata_d = gpio_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_gnt || seq_gnt) begin
                    state_d      = ST_WR;
                    gpio_we_d    = 1'b1;
                    gpio_wdata_d = seq_gnt ? seq_data : cpu_data;
                end
            end
            ST_WR: begin
                if (GAP > 0) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = GAP_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            gap_cnt_q    <= 4'd0;
            gpio_we_q    <= 1'b0;
            gpio_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            gpio_we_q    <= gpio_we_d;
            gpio_wdata_q <= gpio_wdata_d;
        end
    end

    assign gpio_we    = gpio_we_q;
    assign gpio_wdata = gpio_wdata_q;
    assign busy       = (state_q != ST_IDLE);

`ifdef GPIO_ARB_SHADOW_EN
    src_e          src_q, src_d;
    src_e          wr_src_q, wr_src_d;
    logic [DW-1:0] shadow_d;

    // Shadow copies are committed during the strobe cycle, so an aborted
    // write never reaches them.
    always_comb begin
        src_d    = src_q;
        wr_src_d = wr_src_q;
        shadow_d = shadow_q;
        if (cpu_gnt || seq_gnt) begin
            src_d = seq_gnt ? SRC_SEQ : SRC_CPU;
        end
        if (gpio_we_q) begin
            shadow_d = gpio_wdata_q;
            wr_src_d = src_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q    <= SRC_CPU;
            wr_src_q <= SRC_CPU;
            shadow_q <= '0;
        end else begin
            src_q    <= src_d;
            wr_src_q <= wr_src_d;
            shadow_q <= shadow_d;
        end
    end

    assign wr_src = (wr_src_q == SRC_SEQ);
`endif

endmodule

// File: tb/tb_gpio_wr_arbiter.sv
// Directed bench for gpio_wr_arbiter: one GAP=1 instance and one GAP=0
// instance; shadow checks are compiled in with GPIO_ARB_SHADOW_EN.
module tb_gpio_wr_arbiter;
    import gpio_pkg::*;

    localparam logic [31:0] VEC_LED = (32'h0 << GPIOF0_LSB) | (32'(8'hAA) << LED_LSB) | (32'h0 << CNTSET_LSB);
    localparam logic [31:0] VEC_F0  = (32'(22'h3FFFFF) << GPIOF0_LSB) | (32'h0 << CNTSET_LSB);

    logic        clk;
    logic        rst_n;
    logic        cpu_req, seq_req;
    logic [31:0] cpu_data, seq_data;
    logic        cpu_gnt, seq_gnt, gpio_we, busy;
    logic [31:0] gpio_wdata;
    logic        seq_req1;
    logic [31:0] seq_data1;
    logic        cpu_gnt1, seq_gnt1, gpio_we1, busy1;
    logic [31:0] gpio_wdata1;
`ifdef GPIO_ARB_SHADOW_EN
    logic [31:0] shadow0, shadow1;
    logic        wr_src0, wr_src1;
`endif

    int total = 0;
    int bad   = 0;

    gpio_wr_arbiter #(.DW(32), .GAP(1)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_data   (cpu_data),
        .seq_req    (seq_req),
        .seq_data   (seq_data),
        .cpu_gnt    (cpu_gnt),
        .seq_gnt    (seq_gnt),
        .gpio_we    (gpio_we),
        .gpio_wdata (gpio_wdata),
        .busy       (busy)
`ifdef GPIO_ARB_SHADOW_EN
        ,
        .shadow_q   (shadow0),
        .wr_src     (wr_src0)
`endif
    );

    gpio_wr_arbiter #(.DW(32), .GAP(0)) u_dut_gap0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (1'b0),
        .cpu_data   (32'h0),
        .seq_req    (seq_req1),
        .seq_data   (seq_data1),
        .cpu_gnt    (cpu_gnt1),
        .seq_gnt    (seq_gnt1),
        .gpio_we    (gpio_we1),
        .gpio_wdata (gpio_wdata1),
        .busy       (busy1)
`ifdef GPIO_ARB_SHADOW_EN
        ,
        .shadow_q   (shadow1),
        .wr_src     (wr_src1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic cr, input logic [31:0] cd,
                                 input logic sr, input logic [31:0] sd);
        cpu_req  = cr;
        cpu_data = cd;
        seq_req  = sr;
        seq_data = sd;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        repeat (3) nextCycle();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        seq_req1  = 1'b0;
        seq_data1 = 32'h0;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);

        $display("[TB] reset state");
        doReset();
        @(negedge clk);
        checkOutput("rst_we", 32'(gpio_we), 32'd0);
        checkOutput("rst_wdata", gpio_wdata, 32'h0);
        checkOutput("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        checkOutput("rst_seq_gnt", 32'(seq_gnt), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);

        $display("[TB] single cpu write");
        nextCycle();
        applyStimulus(1'b1, VEC_LED, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("c0_cpu_gnt", 32'(cpu_gnt), 32'd1);
        checkOutput("c0_seq_gnt", 32'(seq_gnt), 32'd0);
        checkOutput("c0_busy", 32'(busy), 32'd0);
        nextCycle();
        applyStimulus(1'b0, VEC_LED, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("c1_we", 32'(gpio_we), 32'd1);
        checkOutput("c1_wdata", gpio_wdata, 32'h0000_02A8);
        checkOutput("c1_busy", 32'(busy), 32'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("c2_we", 32'(gpio_we), 32'd0);
        checkOutput("c2_wdata_hold", gpio_wdata, 32'h0000_02A8);
        checkOutput("c2_busy", 32'(busy), 32'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("c3_busy", 32'(busy), 32'd0);

        $display("[TB] round-robin with both requests held");
        doReset();
        applyStimulus(1'b1, 32'h1, 1'b1, 32'h2);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checkOutput($sformatf("rr_cpu_gnt_%0d", c), 32'(cpu_gnt), 32'((c % 6) == 0));
            checkOutput($sformatf("rr_seq_gnt_%0d", c), 32'(seq_gnt), 32'((c % 6) == 3));
            checkOutput($sformatf("rr_we_%0d", c), 32'(gpio_we), 32'((c % 3) == 1));
            if ((c % 6) == 1) checkOutput($sformatf("rr_wdata_%0d", c), gpio_wdata, 32'h1);
            if ((c % 6) == 4) checkOutput($sformatf("rr_wdata_%0d", c), gpio_wdata, 32'h2);
            nextCycle();
        end
        applyStimulus(1'b0, 32'h1, 1'b0, 32'h2);
        @(negedge clk);
        checkOutput("rr_drop_gnt", 32'(cpu_gnt | seq_gnt), 32'd0);
        repeat (3) nextCycle();

        $display("[TB] cpu request dropped during WR/GAP");
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h33);
        @(negedge clk);
        checkOutput("gd_seq_gnt", 32'(seq_gnt), 32'd1);
        nextCycle();
        applyStimulus(1'b1, 32'h44, 1'b0, 32'h33);
        @(negedge clk);
        checkOutput("gd_wr_cpu_gnt", 32'(cpu_gnt), 32'd0);
        checkOutput("gd_wr_wdata", gpio_wdata, 32'h33);
        nextCycle();
        @(negedge clk);
        checkOutput("gd_gap_cpu_gnt", 32'(cpu_gnt), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 32'h44, 1'b0, 32'h33);
        @(negedge clk);
        checkOutput("gd_idle_cpu_gnt", 32'(cpu_gnt), 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("gd_no_write", 32'(gpio_we), 32'd0);
        checkOutput("gd_wdata_hold", gpio_wdata, 32'h33);
        nextCycle();
        applyStimulus(1'b1, 32'h5, 1'b1, 32'h6);
        @(negedge clk);
        checkOutput("flag_cpu_gnt", 32'(cpu_gnt), 32'd1);
        checkOutput("flag_seq_gnt", 32'(seq_gnt), 32'd0);

        $display("[TB] reset during WR");
        nextCycle();
        applyStimulus(1'b0, 32'h5, 1'b0, 32'h6);
        @(negedge clk);
        checkOutput("ab_we_before", 32'(gpio_we), 32'd1);
        checkOutput("ab_wdata_before", gpio_wdata, 32'h5);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("ab_we", 32'(gpio_we), 32'd0);
        checkOutput("ab_wdata", gpio_wdata, 32'h0);
        checkOutput("ab_busy", 32'(busy), 32'd0);
        repeat (2) nextCycle();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput($sformatf("ab_quiet_we_%0d", c), 32'(gpio_we), 32'd0);
            nextCycle();
        end

        $display("[TB] GAP=0 back-to-back sequencer writes");
        seq_req1  = 1'b1;
        seq_data1 = VEC_F0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checkOutput($sformatf("g0_seq_gnt_%0d", c), 32'(seq_gnt1), 32'((c % 2) == 0));
            checkOutput($sformatf("g0_we_%0d", c), 32'(gpio_we1), 32'((c % 2) == 1));
            if (c == 1) checkOutput("g0_wdata", gpio_wdata1, 32'hFFFF_FC00);
`ifdef GPIO_ARB_SHADOW_EN
            if (c == 1) begin
                checkOutput("sh_before", shadow1, 32'h0);
                checkOutput("sh_src_before", 32'(wr_src1), 32'd0);
            end
            if (c == 2) begin
                checkOutput("sh_value", shadow1, 32'hFFFF_FC00);
                checkOutput("sh_src", 32'(wr_src1), 32'd1);
            end
`endif
            nextCycle();
        end
        seq_req1 = 1'b0;
        repeat (2) nextCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
